// File: rtl/cpu_core_params.sv
// Core-wide shared types.
package cpu_core_params;
    typedef logic [31:0] ProgramCount;
endpackage

// File: rtl/ex_stage_params.sv
// Types shared by the execute stage, its divider and its neighbouring stages.
package ex_stage_params;
    import cpu_core_params::*;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
        ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
    } AluOp;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} DivState;

    typedef struct packed {
        logic        valid;
        ProgramCount program_count;
        AluOp        alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store_data;
        logic [4:0]  destination_register;
        logic        register_write;
        logic        memory_read;
        logic        memory_write;
    } IDToEXData;

    typedef struct packed {
        logic        valid;
        ProgramCount program_count;
        logic [31:0] alu_result;
        logic [4:0]  destination_register;
        logic        register_write;
        logic        result_is_from_memory;
    } EXToIOData;

    typedef struct packed {
        logic [4:0] destination_register;
    } EXToIDBackPassData;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? -value : value;
    endfunction
endpackage

// File: rtl/ex_divider.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// EX_DIV_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module ex_divider
    import ex_stage_params::*;
#(
    parameter int DIV_ITERATIONS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int COUNT_WIDTH = $clog2(DIV_ITERATIONS) + 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DIV_ITERATIONS - 1);

    DivState                state, state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [31:0]            rem, quo, divisor_mag;
    logic                   neg_quotient, neg_remainder;
    logic [32:0]            partial, diff;

    // quo starts as the dividend and shifts quotient bits in from the right.
    assign partial = {rem, quo[31]};
    assign diff    = partial - {1'b0, divisor_mag};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= DIV_IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults first, so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) begin
`ifdef EX_DIV_ZERO_FAST_EN
                state_next = (divisor == 32'h0) ? DIV_DONE : DIV_BUSY;
`else
                state_next = DIV_BUSY;
`endif
            end
            DIV_BUSY: if (count == LAST_COUNT) state_next = DIV_DONE;
            DIV_DONE: if (ack) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            divisor_mag   <= '0;
            neg_quotient  <= 1'b0;
            neg_remainder <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count         <= '0;
            rem           <= '0;
            quo           <= magnitude(dividend, is_signed);
            divisor_mag   <= magnitude(divisor, is_signed);
            neg_quotient  <= is_signed & (dividend[31] ^ divisor[31]);
            neg_remainder <= is_signed & dividend[31];
`ifdef EX_DIV_ZERO_FAST_EN
            if (divisor == 32'h0) begin
                rem <= magnitude(dividend, is_signed);
                quo <= '1;
            end
`endif
        end else if (state == DIV_BUSY) begin
            count <= count + 1'b1;
            rem   <= diff[32] ? partial[31:0] : diff[31:0];
            quo   <= {quo[30:0], ~diff[32]};
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_quotient  ? -quo : quo;
    assign remainder = neg_remainder ? -rem : rem;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO with multiply and multi-cycle divide, data-SRAM request.
// EX_DIV_ZERO_FAST_EN (see ex_divider) shortens divide-by-zero latency only.
module ex_stage
    import ex_stage_params::*;
#(
    parameter int DIV_ITERATIONS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_allow_in,
    output logic              ex_allow_in,
    input  IDToEXData         id_to_ex_bus,
    output EXToIOData         ex_to_io_bus,
    output EXToIDBackPassData ex_to_id_back_pass_bus,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [31:0]       data_sram_addr,
    output logic [31:0]       data_sram_wdata
);
    IDToEXData   ex_data;
    logic        ex_valid, ex_ready_go, handoff;
    logic        is_div, div_busy, div_done, mult_signed;
    logic [31:0] hi, lo, div_quotient, div_remainder, alu_result;
    logic [63:0] product;

    // ex_data.valid doubles as the stage-valid flop; the payload only moves on a real instruction.
    assign ex_valid    = ex_data.valid;
    assign is_div      = ex_data.alu_op inside {ALU_DIV, ALU_DIVU};
    assign ex_ready_go = is_div ? div_done : 1'b1;
    assign ex_allow_in = !ex_valid | (ex_ready_go & io_allow_in);
    assign handoff     = ex_valid & ex_ready_go & io_allow_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  ex_data       <= '0;
        else if (ex_allow_in) begin
            if (id_to_ex_bus.valid)  ex_data       <= id_to_ex_bus;
            else                     ex_data.valid <= 1'b0;
        end
    end

    ex_divider #(.DIV_ITERATIONS(DIV_ITERATIONS)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (ex_valid & is_div & !div_busy & !div_done),
        .ack       (handoff & is_div),
        .is_signed (ex_data.alu_op == ALU_DIV),
        .dividend  (ex_data.src1),
        .divisor   (ex_data.src2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign mult_signed = (ex_data.alu_op == ALU_MULT);
    assign product = {{32{mult_signed & ex_data.src1[31]}}, ex_data.src1}
                   * {{32{mult_signed & ex_data.src2[31]}}, ex_data.src2};

    // HI/LO change only when the producing instruction leaves EX, never while it stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (handoff) begin
            case (ex_data.alu_op)
                ALU_MULT, ALU_MULTU: {hi, lo} <= product;
                ALU_DIV, ALU_DIVU: begin
                    hi <= div_remainder;
                    lo <= div_quotient;
                end
                ALU_MTHI: hi <= ex_data.src1;
                ALU_MTLO: lo <= ex_data.src1;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_result = '0;
        case (ex_data.alu_op)
            ALU_ADD:  alu_result = ex_data.src1 + ex_data.src2;
            ALU_SUB:  alu_result = ex_data.src1 - ex_data.src2;
            ALU_SLT:  alu_result = {31'b0, $signed(ex_data.src1) < $signed(ex_data.src2)};
            ALU_SLTU: alu_result = {31'b0, ex_data.src1 < ex_data.src2};
            ALU_AND:  alu_result = ex_data.src1 & ex_data.src2;
            ALU_OR:   alu_result = ex_data.src1 | ex_data.src2;
            ALU_XOR:  alu_result = ex_data.src1 ^ ex_data.src2;
            ALU_NOR:  alu_result = ~(ex_data.src1 | ex_data.src2);
            ALU_SLL:  alu_result = ex_data.src2 << ex_data.src1[4:0];
            ALU_SRL:  alu_result = ex_data.src2 >> ex_data.src1[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(ex_data.src2) >>> ex_data.src1[4:0]);
            ALU_LUI:  alu_result = {ex_data.src2[15:0], 16'h0};
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            ALU_MTHI, ALU_MTLO: alu_result = ex_data.src1;
            default:  alu_result = '0;
        endcase
    end

    // The request rides the handoff cycle, so a stalled load/store never issues twice.
    assign data_sram_en    = ex_valid & (ex_data.memory_read | ex_data.memory_write) & io_allow_in;
    assign data_sram_wen   = {4{ex_data.memory_write & data_sram_en}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ex_data.store_data;

    always_comb begin
        ex_to_io_bus.valid                 = ex_valid & ex_ready_go;
        ex_to_io_bus.program_count         = ex_data.program_count;
        ex_to_io_bus.alu_result            = alu_result;
        ex_to_io_bus.destination_register  = ex_data.destination_register;
        ex_to_io_bus.register_write        = ex_data.register_write;
        ex_to_io_bus.result_is_from_memory = ex_data.memory_read;
        ex_to_id_back_pass_bus.destination_register =
            (ex_valid & ex_data.register_write) ? ex_data.destination_register : 5'd0;
    end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus a randomized instruction stream
// checked against a cycle-level reference model of the stage's observable behaviour.
module tb_ex_stage;
    import ex_stage_params::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_allow_in;
    logic              ex_allow_in;
    IDToEXData         id_to_ex_bus;
    EXToIOData         ex_to_io_bus;
    EXToIDBackPassData ex_to_id_back_pass_bus;
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [31:0]       data_sram_addr;
    logic [31:0]       data_sram_wdata;

    always #5 clock = ~clock;

    ex_stage #(.DIV_ITERATIONS(32)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_allow_in            (io_allow_in),
        .ex_allow_in            (ex_allow_in),
        .id_to_ex_bus           (id_to_ex_bus),
        .ex_to_io_bus           (ex_to_io_bus),
        .ex_to_id_back_pass_bus (ex_to_id_back_pass_bus),
        .data_sram_en           (data_sram_en),
        .data_sram_wen          (data_sram_wen),
        .data_sram_addr         (data_sram_addr),
        .data_sram_wdata        (data_sram_wdata)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    IDToEXData   pend_q[$];
    IDToEXData   cur;
    bit          in_ex;
    int          age;
    logic [31:0] m_hi, m_lo;
    logic [31:0] res_log[$];
    int          stall_cycles, sram_pulses;
    logic [31:0] last_addr;
    logic [3:0]  last_wen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_divide(input IDToEXData d);
        return d.alu_op == ALU_DIV || d.alu_op == ALU_DIVU;
    endfunction

    // Cycles from entry until the instruction may leave EX.
    function automatic int latency(input IDToEXData d);
        if (!is_divide(d)) return 0;
`ifdef EX_DIV_ZERO_FAST_EN
        if (d.src2 == 32'h0) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] ref_alu(input IDToEXData d, input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] a = d.src1;
        logic [31:0] b = d.src2;
        int sh = int'(a[4:0]);
        case (d.alu_op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA:  return 32'($signed(b) >>> sh);
            ALU_LUI:  return b[15:0] * 32'h10000;
            ALU_MFHI: return hi;
            ALU_MFLO: return lo;
            ALU_MTHI, ALU_MTLO: return a;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] am;
        longint x, y;
        if (b == 32'h0) begin
            am = (sgn && a[31]) ? -a : a;
            q  = (sgn && a[31]) ? 32'h1 : 32'hFFFFFFFF;
            r  = (sgn && a[31]) ? -am : am;
        end else if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            q = 32'(x / y);
            r = 32'(x % y);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic void ref_hilo(input IDToEXData d, inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        case (d.alu_op)
            ALU_MULT: begin
                sp = longint'($signed(d.src1)) * longint'($signed(d.src2));
                {hi, lo} = sp;
            end
            ALU_MULTU: begin
                up = 64'(d.src1) * 64'(d.src2);
                {hi, lo} = up;
            end
            ALU_DIV:  ref_div(d.src1, d.src2, 1'b1, lo, hi);
            ALU_DIVU: ref_div(d.src1, d.src2, 1'b0, lo, hi);
            ALU_MTHI: hi = d.src1;
            ALU_MTLO: lo = d.src1;
            default: ;
        endcase
    endfunction

    function automatic IDToEXData mk(input AluOp op, input logic [31:0] a, input logic [31:0] b);
        IDToEXData d = '0;
        d.valid                = 1'b1;
        d.program_count        = $urandom;
        d.alu_op               = op;
        d.src1                 = a;
        d.src2                 = b;
        d.store_data           = $urandom;
        d.destination_register = 5'($urandom);
        d.register_write       = 1'b1;
        return d;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h7FFFFFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic IDToEXData rand_instr();
        IDToEXData d = mk(AluOp'(5'($urandom_range(0, 19))), rand_operand(), rand_operand());
        d.register_write = 1'($urandom);
        if (d.alu_op == ALU_ADD && $urandom_range(0, 1) == 1) begin
            d.memory_read  = 1'($urandom);
            d.memory_write = !d.memory_read;
        end
        return d;
    endfunction

    // One clock: drive at the falling edge, compare once settled, advance the model.
    task automatic step(input bit io_ok);
        bit          exp_valid, exp_allow, mem;
        logic [31:0] exp_res;
        @(negedge clock);
        io_allow_in  = io_ok;
        id_to_ex_bus = (pend_q.size() > 0) ? pend_q[0] : '0;
        #1;
        exp_valid = in_ex && (age >= latency(cur));
        exp_allow = !in_ex || (exp_valid && io_ok);
        mem       = in_ex && (cur.memory_read || cur.memory_write);
        exp_res   = ref_alu(cur, m_hi, m_lo);
        check("ex_allow_in", 32'(ex_allow_in), 32'(exp_allow));
        check("io_valid", 32'(ex_to_io_bus.valid), 32'(exp_valid));
        check("sram_en", 32'(data_sram_en), 32'(mem && io_ok));
        check("sram_wen", 32'(data_sram_wen), (in_ex && cur.memory_write && io_ok) ? 32'hF : 32'h0);
        check("backpass", 32'(ex_to_id_back_pass_bus.destination_register),
              (in_ex && cur.register_write) ? 32'(cur.destination_register) : 32'h0);
        if (exp_valid) begin
            check("pc", ex_to_io_bus.program_count, cur.program_count);
            if (!(cur.alu_op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU}))
                check("alu_result", ex_to_io_bus.alu_result, exp_res);
            check("dest", 32'(ex_to_io_bus.destination_register), 32'(cur.destination_register));
            check("reg_write", 32'(ex_to_io_bus.register_write), 32'(cur.register_write));
            check("from_mem", 32'(ex_to_io_bus.result_is_from_memory), 32'(cur.memory_read));
        end
        if (mem && io_ok) begin
            check("sram_addr", data_sram_addr, exp_res);
            check("sram_wdata", data_sram_wdata, cur.store_data);
        end
        if (!ex_allow_in) stall_cycles++;
        if (data_sram_en) begin
            sram_pulses++;
            last_addr = data_sram_addr;
            last_wen  = data_sram_wen;
        end
        if (ex_to_io_bus.valid && io_ok) res_log.push_back(ex_to_io_bus.alu_result);
        if (exp_valid && io_ok) ref_hilo(cur, m_hi, m_lo);
        if (exp_allow) begin
            age   = 0;
            in_ex = (pend_q.size() > 0);
            if (in_ex) cur = pend_q.pop_front();
        end else begin
            age++;
        end
    endtask

    task automatic drain(input bit full_io);
        int n = 0;
        while (pend_q.size() > 0 || in_ex) begin
            if (n == 4000) begin
                check("drain_timeout", 32'(n), 32'h0);
                break;
            end
            step(full_io ? 1'b1 : ($urandom_range(0, 3) != 0));
            n++;
        end
    endtask

    task automatic clear_logs();
        res_log.delete();
        stall_cycles = 0;
        sram_pulses  = 0;
    endtask

    task automatic expect_results(input string tag, input logic [31:0] exp[$]);
        check({tag, "_count"}, 32'(res_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < res_log.size(); i++)
            check($sformatf("%s_%0d", tag, i), res_log[i], exp[i]);
    endtask

    initial begin
        IDToEXData sw;
        int        n;
        reset        = 1'b0;
        io_allow_in  = 1'b0;
        id_to_ex_bus = '0;
        in_ex        = 1'b0;
        age          = 0;
        cur          = '0;
        m_hi         = '0;
        m_lo         = '0;
        clear_logs();
        #12;
        check("rst_io_valid", 32'(ex_to_io_bus.valid), 32'h0);
        check("rst_allow_in", 32'(ex_allow_in), 32'h1);
        check("rst_sram_en", 32'(data_sram_en), 32'h0);
        check("rst_sram_wen", 32'(data_sram_wen), 32'h0);
        check("rst_backpass", 32'(ex_to_id_back_pass_bus.destination_register), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        clear_logs();
        pend_q.push_back(mk(ALU_ADD, 32'h7FFFFFFF, 32'h1));
        drain(1'b1);
        expect_results("add_wrap", '{32'h80000000});
        check("add_no_stall", 32'(stall_cycles), 32'h0);

        clear_logs();
        pend_q.push_back(mk(ALU_DIV, 32'hFFFFFFF9, 32'h2));
        pend_q.push_back(mk(ALU_MFLO, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_MFHI, 32'h0, 32'h0));
        drain(1'b1);
        expect_results("div_neg", '{32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF});
        check("div_stall", 32'(stall_cycles), 32'd33);

        clear_logs();
        pend_q.push_back(mk(ALU_DIVU, 32'h5, 32'h0));
        pend_q.push_back(mk(ALU_MFLO, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_MFHI, 32'h0, 32'h0));
        drain(1'b1);
        expect_results("divu_zero", '{32'h0, 32'hFFFFFFFF, 32'h5});
`ifdef EX_DIV_ZERO_FAST_EN
        check("divu_zero_stall", 32'(stall_cycles), 32'd1);
`else
        check("divu_zero_stall", 32'(stall_cycles), 32'd33);
`endif

        clear_logs();
        sw = mk(ALU_ADD, 32'h1000, 32'h24);
        sw.memory_write   = 1'b1;
        sw.register_write = 1'b0;
        pend_q.push_back(sw);
        step(1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        check("sw_pulses", 32'(sram_pulses), 32'd1);
        check("sw_addr", last_addr, 32'h1024);
        check("sw_wen", 32'(last_wen), 32'hF);

        clear_logs();
        pend_q.push_back(mk(ALU_MULT, 32'hFFFFFFFE, 32'h3));
        pend_q.push_back(mk(ALU_MFLO, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_MFHI, 32'h0, 32'h0));
        drain(1'b1);
        expect_results("mult_neg", '{32'h0, 32'hFFFFFFFA, 32'hFFFFFFFF});

        // Abort a divide part-way through its iterations.
        pend_q.push_back(mk(ALU_DIV, 32'd100, 32'd7));
        n = 0;
        while (!(in_ex && age == 11) && n < 100) begin
            step(1'b1);
            n++;
        end
        check("abort_reached", 32'(in_ex && age == 11), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_io_valid", 32'(ex_to_io_bus.valid), 32'h0);
        check("abort_allow_in", 32'(ex_allow_in), 32'h1);
        check("abort_sram_en", 32'(data_sram_en), 32'h0);
        in_ex = 1'b0;
        age   = 0;
        m_hi  = '0;
        m_lo  = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear_logs();
        pend_q.push_back(mk(ALU_MFHI, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_MFLO, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_DIV, 32'd100, 32'd7));
        pend_q.push_back(mk(ALU_MFLO, 32'h0, 32'h0));
        pend_q.push_back(mk(ALU_MFHI, 32'h0, 32'h0));
        drain(1'b1);
        expect_results("after_abort", '{32'h0, 32'h0, 32'h0, 32'd14, 32'd2});
        check("after_abort_stall", 32'(stall_cycles), 32'd33);

        for (int i = 0; i < 250; i++) pend_q.push_back(rand_instr());
        drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
